// File: rtl/decoder_defs.sv
// Shared state encodings and sizing helper for the one-hot hold decoder.
package decoder_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  // Counter only needs to reach HOLD_CYCLES-1, but never narrower than one bit.
  function automatic int calc_cnt_w(input int hold_cycles);
    return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-length timer: load to HOLD_CYCLES-1, count down to zero and stick there.
// Latency: zero flag is registered; load wins over decrement.
module hold_timer
  import decoder_defs::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CNT_W = calc_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_decoder_hold.sv
// Binary-to-one-hot decoder holding each value HOLD_CYCLES cycles, with optional auto-scan.
// Latency: y one cycle after accept; in_ready low while busy or scanning, no input buffering.
module onehot_decoder_hold
  import decoder_defs::*;
#(
  parameter int CODE_W      = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CODE_W-1:0]      in_code,
  output logic                   in_ready,
  input  logic                   scan_en,
  output logic [2**CODE_W-1:0]   y,
  output logic                   y_valid,
  output logic [CODE_W-1:0]      cur_code,
  output logic                   done
);

  localparam int Y_W = 2**CODE_W;

  logic [1:0]        state;
  logic              timer_zero;
  logic              timer_load;
  logic              start_scan;
  logic              start_hold;
  logic              scan_step;
  logic [CODE_W-1:0] next_code;

  assign in_ready   = (state == ST_IDLE) && !scan_en;
  assign start_scan = (state == ST_IDLE) && scan_en;
  assign start_hold = in_valid && in_ready;
  // Scan only advances while still requested; otherwise the last code just expires.
  assign scan_step  = (state == ST_SCAN) && timer_zero && scan_en;
  assign timer_load = start_scan || start_hold || scan_step;
  assign next_code  = cur_code + CODE_W'(1);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .zero (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      y        <= '0;
      y_valid  <= 1'b0;
      cur_code <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_scan) begin
            y        <= Y_W'(1);
            cur_code <= '0;
            y_valid  <= 1'b1;
            state    <= ST_SCAN;
          end else if (start_hold) begin
            y        <= Y_W'(1) << in_code;
            cur_code <= in_code;
            y_valid  <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (timer_zero) begin
            y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (timer_zero) begin
            if (scan_en) begin
              cur_code <= next_code;
              y        <= Y_W'(1) << next_code;
            end else begin
              y       <= '0;
              y_valid <= 1'b0;
              done    <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        default: begin
          y       <= '0;
          y_valid <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
